// File: rtl/seg7_scan_driver_if.sv
// Bus between the application logic and the 7-segment scan driver: update
// strobe plus display data in, segment/digit pins and status out.
interface seg7_scan_driver_if #(
    parameter int DIGITS   = 4,
    parameter int PWM_BITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank;
    logic [PWM_BITS-1:0]   bright;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     dig;
    logic                  frame;
    logic                  pending;

    modport master (
        output load, value, dp, blank, bright,
        input  seg, dig, frame, pending
    );

    modport slave (
        input  load, value, dp, blank, bright,
        output seg, dig, frame, pending
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for multi-digit 7-segment displays with guard
// band, PWM dimming, leading-zero blanking and frame-aligned double buffering.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 4000,
    parameter int GUARD       = 16,
    parameter int PWM_BITS    = 4,
    parameter bit LZ_SUPPRESS = 1'b0,
    parameter bit SEG_POL     = 1'b1,
    parameter bit DIG_POL     = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int PCNT_W = $clog2(SCAN_DIV);
    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(SCAN_DIV - 1);
    localparam logic [PCNT_W-1:0] PCNT_GUARD = PCNT_W'(GUARD);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF    = {8{~SEG_POL}};
    localparam logic [DIGITS-1:0] DIG_OFF    = {DIGITS{~DIG_POL}};

    typedef struct packed {
        logic [4*DIGITS-1:0] value;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   blank;
        logic [PWM_BITS-1:0] bright;
    } disp_buf_t;

    logic [PCNT_W-1:0]   r_pcnt;
    logic [SLOT_W-1:0]   r_slot;
    logic [PWM_BITS-1:0] r_pwm;
    disp_buf_t           r_active;
    disp_buf_t           r_pending_buf;
    logic                r_pending;
    logic                r_frame;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_dig;

    logic                w_boundary;
    logic                w_commit;
    logic                w_bright_ok;
    logic                w_lit;
    logic [3:0]          w_nibble;
    logic [6:0]          w_glyph;
    logic [3:0]          w_nibs [DIGITS];
    logic [DIGITS-1:0]   w_suppress;
    logic [DIGITS-1:0]   w_onehot;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            4'hF: hex_glyph = 7'h71;
        endcase
    endfunction

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign w_nibs[gi] = r_active.value[4*gi +: 4];
    end

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        logic zero_run;
        // NOTE: every output of this block gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
        zero_run   = 1'b1;
        w_suppress = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (w_nibs[i] == 4'h0);
            w_suppress[i] = LZ_SUPPRESS && zero_run && (i != 0);
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_onehot[i] = (r_slot == SLOT_W'(i));
        end
    end

    assign w_boundary  = (r_pcnt == PCNT_LAST) && (r_slot == SLOT_LAST);
    assign w_commit    = w_boundary && r_pending;
    assign w_nibble    = w_nibs[r_slot];
    assign w_glyph     = hex_glyph(w_nibble);
    assign w_bright_ok = (&r_active.bright) || (r_pwm < r_active.bright);
    assign w_lit       = (r_pcnt >= PCNT_GUARD)
                      && !r_active.blank[r_slot]
                      && !w_suppress[r_slot]
                      && w_bright_ok;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcnt <= '0;
            r_slot <= '0;
            r_pwm  <= '0;
        end else begin
            // NOTE: non-blocking updates let every register sample pre-edge values; blocking ones would chain within a single edge.
            r_pwm <= r_pwm + 1'b1;
            if (r_pcnt == PCNT_LAST) begin
                r_pcnt <= '0;
                r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end
        end
    end

    // A LOAD on the boundary cycle commits the older pending data and keeps the new one waiting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the buffers are plain flops, not a RAM, so they take the asynchronous reset like any other state.
            r_active.value  <= '0;
            r_active.dp     <= '0;
            r_active.blank  <= '1;
            r_active.bright <= '1;
            r_pending_buf   <= '0;
            r_pending       <= 1'b0;
            r_frame         <= 1'b0;
        end else begin
            r_frame <= w_commit;
            if (w_commit) begin
                r_active <= r_pending_buf;
            end
            if (bus.load) begin
                r_pending_buf <= {bus.value, bus.dp, bus.blank, bus.bright};
                r_pending     <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg <= SEG_OFF;
            r_dig <= DIG_OFF;
        end else if (w_lit) begin
            r_seg <= {r_active.dp[r_slot], w_glyph} ^ SEG_OFF;
            r_dig <= w_onehot ^ DIG_OFF;
        end else begin
            r_seg <= SEG_OFF;
            r_dig <= DIG_OFF;
        end
    end

    assign bus.seg     = r_seg;
    assign bus.dig     = r_dig;
    assign bus.frame   = r_frame;
    assign bus.pending = r_pending;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (leading-zero suppression off/on)
// compared every cycle against a time-indexed model, plus directed literal checks.
module tb_seg7_scan_driver;
    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int GUARD     = 1;
    localparam int PWM_BITS  = 2;
    localparam int FRAME_LEN = DIGITS * SCAN_DIV;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [1:0]  bright;
    } disp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   frame_cnt = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan_driver_if #(.DIGITS(DIGITS), .PWM_BITS(PWM_BITS)) bus_a ();
    seg7_scan_driver_if #(.DIGITS(DIGITS), .PWM_BITS(PWM_BITS)) bus_b ();

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .PWM_BITS(PWM_BITS),
        .LZ_SUPPRESS(1'b0), .SEG_POL(1'b1), .DIG_POL(1'b1)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a)
    );

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .PWM_BITS(PWM_BITS),
        .LZ_SUPPRESS(1'b1), .SEG_POL(1'b1), .DIG_POL(1'b1)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: outputs are a pure function of cycles since reset and the active buffer.
    function automatic void expect_out(input disp_t a, input int t, input bit lz,
                                       output logic [7:0] seg, output logic [3:0] dig);
        int pc, sl, pw, nib;
        bit lit;
        pc  = t % SCAN_DIV;
        sl  = (t / SCAN_DIV) % DIGITS;
        pw  = t % (1 << PWM_BITS);
        nib = int'((a.value >> (4 * sl)) & 16'hF);
        lit = (pc >= GUARD) && (a.blank[sl] == 1'b0)
           && !(lz && sl > 0 && (a.value >> (4 * sl)) == 16'h0)
           && (a.bright == 2'b11 || pw < int'(a.bright));
        seg = lit ? {a.dp[sl], hex_tab[nib]} : 8'h00;
        dig = lit ? 4'(1 << sl) : 4'h0;
    endfunction

    int         m_t    = 0;
    disp_t      m_act  = '{16'h0, 4'h0, 4'hF, 2'b11};
    disp_t      m_buf  = '{16'h0, 4'h0, 4'h0, 2'b00};
    bit         m_pend = 1'b0;
    bit         exp_frame = 1'b0;
    logic [7:0] exp_seg_a = 8'h00, exp_seg_b = 8'h00;
    logic [3:0] exp_dig_a = 4'h0,  exp_dig_b = 4'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t       = 0;
            m_act     = '{16'h0, 4'h0, 4'hF, 2'b11};
            m_buf     = '{16'h0, 4'h0, 4'h0, 2'b00};
            m_pend    = 1'b0;
            exp_frame = 1'b0;
            exp_seg_a = 8'h00; exp_dig_a = 4'h0;
            exp_seg_b = 8'h00; exp_dig_b = 4'h0;
        end else begin
            expect_out(m_act, m_t, 1'b0, exp_seg_a, exp_dig_a);
            expect_out(m_act, m_t, 1'b1, exp_seg_b, exp_dig_b);
            exp_frame = (m_t % FRAME_LEN == FRAME_LEN - 1) && m_pend;
            if (exp_frame) begin
                m_act  = m_buf;
                m_pend = 1'b0;
            end
            if (bus_a.load) begin
                m_buf  = '{bus_a.value, bus_a.dp, bus_a.blank, bus_a.bright};
                m_pend = 1'b1;
            end
            m_t++;
        end
    end

    always @(negedge clk) begin
        check("seg_a", bus_a.seg, exp_seg_a);
        check("dig_a", bus_a.dig, exp_dig_a);
        check("seg_b", bus_b.seg, exp_seg_b);
        check("dig_b", bus_b.dig, exp_dig_b);
        check("frame_a", bus_a.frame, exp_frame);
        check("frame_b", bus_b.frame, exp_frame);
        check("pending_a", bus_a.pending, m_pend);
        check("pending_b", bus_b.pending, m_pend);
        if (bus_a.frame === 1'b1) frame_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic drive(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                         input logic [1:0] br);
        bus_a.value = v;  bus_a.dp = dp;  bus_a.blank = bl;  bus_a.bright = br;
        bus_b.value = v;  bus_b.dp = dp;  bus_b.blank = bl;  bus_b.bright = br;
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                        input logic [1:0] br);
        drive(v, dp, bl, br);
        bus_a.load = 1'b1;
        bus_b.load = 1'b1;
        step();
        bus_a.load = 1'b0;
        bus_b.load = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (bus_a.frame !== 1'b1 && n < 2 * FRAME_LEN);
        check(name, bus_a.frame, 1'b1);
    endtask

    task automatic count_lit(input int n, output int lit);
        lit = 0;
        repeat (n) begin
            step();
            if (bus_a.dig !== 4'h0) lit++;
        end
    endtask

    initial begin
        int f0;
        int lit;
        bus_a.load = 1'b0;
        bus_b.load = 1'b0;
        drive(16'h0, 4'h0, 4'h0, 2'b00);

        steps(3);
        check("reset_dig", bus_a.dig, 4'h0);
        check("reset_seg", bus_a.seg, 8'h00);
        check("reset_pending", bus_a.pending, 1'b0);

        // Idle after reset: BLANK resets to all ones, so nothing lights.
        rst_n = 1'b1;
        f0 = frame_cnt;
        count_lit(64, lit);
        check("idle_lit", lit, 0);
        check("idle_frames", frame_cnt - f0, 0);

        f0 = frame_cnt;
        load(16'h12AF, 4'b0100, 4'h0, 2'b11);
        check("load_pending", bus_a.pending, 1'b1);
        wait_frame("frame_12af");
        check("pending_cleared", bus_a.pending, 1'b0);
        steps(2);
        check("slot0_dig", bus_a.dig, 4'b0001);
        check("slot0_seg", bus_a.seg, 8'h71);
        steps(7);
        check("guard_dig", bus_a.dig, 4'b0000);
        step();
        check("slot1_dig", bus_a.dig, 4'b0010);
        check("slot1_seg", bus_a.seg, 8'h77);
        steps(8);
        check("slot2_dig", bus_a.dig, 4'b0100);
        check("slot2_seg", bus_a.seg, 8'hDB);
        steps(8);
        check("slot3_dig", bus_a.dig, 4'b1000);
        check("slot3_seg", bus_a.seg, 8'h06);
        check("frames_12af", frame_cnt - f0, 1);

        // Two loads 3 cycles apart in one frame: only the later one shows.
        f0 = frame_cnt;
        load(16'h3456, 4'h0, 4'h0, 2'b11);
        steps(2);
        load(16'h789A, 4'h0, 4'h0, 2'b11);
        wait_frame("frame_latest");
        steps(2);
        check("latest_seg0", bus_a.seg, 8'h77);
        steps(8);
        check("latest_seg1", bus_a.seg, 8'h6F);
        steps(30);
        check("latest_frames", frame_cnt - f0, 1);

        // Load Y mid-frame, then Z exactly on the boundary edge (edge 192).
        load(16'h0005, 4'h0, 4'h0, 2'b11);
        steps(22);
        load(16'h000C, 4'h0, 4'h0, 2'b11);
        check("coinc_frame", bus_a.frame, 1'b1);
        check("coinc_pending", bus_a.pending, 1'b1);
        steps(2);
        check("coinc_old_seg", bus_a.seg, 8'h6D);
        steps(30);
        check("coinc_frame2", bus_a.frame, 1'b1);
        check("coinc_pending2", bus_a.pending, 1'b0);
        steps(2);
        check("coinc_new_seg", bus_a.seg, 8'h39);

        load(16'h8888, 4'h0, 4'h0, 2'b01);
        wait_frame("frame_dim");
        count_lit(FRAME_LEN, lit);
        check("dim_25pct_lit", lit, 4);
        load(16'h8888, 4'h0, 4'h0, 2'b00);
        wait_frame("frame_off");
        count_lit(FRAME_LEN, lit);
        check("bright0_lit", lit, 0);

        load(16'h0030, 4'h0, 4'h0, 2'b11);
        wait_frame("frame_lz");
        steps(2);
        check("lz_d0_dig", bus_b.dig, 4'b0001);
        check("lz_d0_seg", bus_b.seg, 8'h3F);
        steps(8);
        check("lz_d1_dig", bus_b.dig, 4'b0010);
        check("lz_d1_seg", bus_b.seg, 8'h4F);
        steps(8);
        check("lz_d2_dark", bus_b.dig, 4'b0000);
        check("nolz_d2_dig", bus_a.dig, 4'b0100);
        steps(8);
        check("lz_d3_dark", bus_b.dig, 4'b0000);
        check("nolz_d3_seg", bus_a.seg, 8'h3F);

        // Asynchronous reset mid-slot with an update pending.
        load(16'hFFFF, 4'hF, 4'h0, 2'b11);
        steps(2);
        rst_n = 1'b0;
        #1;
        check("arst_dig_a", bus_a.dig, 4'h0);
        check("arst_seg_a", bus_a.seg, 8'h00);
        check("arst_pending", bus_a.pending, 1'b0);
        steps(2);
        rst_n = 1'b1;
        f0 = frame_cnt;
        count_lit(40, lit);
        check("post_reset_lit", lit, 0);
        check("post_reset_frames", frame_cnt - f0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
